// File: rtl/dma_filter_arbiter_pkg.sv
// Shared types for the DMA write filter/arbiter.
// Holds the FSM encoding, table entry layout and match helper.
package dma_filter_pkg;

  localparam int AW = 32;
  localparam logic [AW-1:0] RST_BASE_REGLK = 32'hF520_6000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_SEND  = 2'd2
  } state_e;

  typedef struct packed {
    logic [AW-1:0] base;
    logic [AW-1:0] mask;
    logic          en;
  } entry_t;

  function automatic logic entry_hit(
    input entry_t        e,
    input logic [AW-1:0] a
  );
    return e.en && ((a & e.mask) == (e.base & e.mask));
  endfunction

endpackage

// File: rtl/dma_filter_arbiter_if.sv
// Requester-side and downstream write handshakes of the filter.
// master drives requests and out_ready; slave is the filter itself.
interface dma_filter_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import dma_filter_pkg::*;

  localparam int SW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*AW-1:0] req_addr;
  logic [NUM_REQ*AW-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  out_valid;
  logic [AW-1:0]         out_addr;
  logic [AW-1:0]         out_data;
  logic [SW-1:0]         out_src;
  logic                  out_ready;

  modport master (
    output req_valid, req_addr, req_data, out_ready,
    input  req_ready, out_valid, out_addr, out_data, out_src
  );

  modport slave (
    input  req_valid, req_addr, req_data, out_ready,
    output req_ready, out_valid, out_addr, out_data, out_src
  );

endinterface

// File: rtl/dma_filter_arbiter_rr.sv
// Round-robin pointer, one-hot grant and index encode.
// The pointer moves past the winner only when adv_i takes the grant.
module dma_rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic                       adv_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [$clog2(NUM_REQ)-1:0] idx_o,
  output logic                       vld_o
);
  localparam int SW = $clog2(NUM_REQ);

  logic [SW-1:0] ptr_q, ptr_d;
  logic [SW-1:0] cand;

  // Scan from the farthest offset down so the nearest valid wins.
  always_comb begin
    vld_o = 1'b0;
    idx_o = '0;
    gnt_o = '0;
    cand  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = SW'((int'(ptr_q) + i) % NUM_REQ);
      if (req_i[cand]) begin
        vld_o = 1'b1;
        idx_o = cand;
      end
    end
    gnt_o[idx_o] = vld_o;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (adv_i && vld_o) begin
      if (idx_o == SW'(NUM_REQ - 1)) ptr_d = '0;
      else                           ptr_d = idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/dma_filter_arbiter.sv
// Round-robin DMA write arbiter with a lockable blocked-address table.
// Define DMA_FILTER_VIOL_LOG_EN to add the violation log outputs.
module dma_filter_arbiter
  import dma_filter_pkg::*;
#(
  parameter int            NUM_REQ     = 4,
  parameter int            NUM_ENTRIES = 4,
  parameter logic [AW-1:0] RST_BASE0   = RST_BASE_REGLK
) (
  input  logic                           clk,
  input  logic                           rst,
  dma_filter_arbiter_if.slave            bus,
  input  logic                           cfg_we,
  input  logic [$clog2(NUM_ENTRIES)-1:0] cfg_idx,
  input  logic [AW-1:0]                  cfg_base,
  input  logic [AW-1:0]                  cfg_mask,
  input  logic                           cfg_en,
  input  logic                           cfg_lock,
  output logic                           locked,
  output logic                           viol_pulse,
  output logic [$clog2(NUM_REQ)-1:0]     viol_src
`ifdef DMA_FILTER_VIOL_LOG_EN
  ,
  input  logic                           log_clr,
  output logic [15:0]                    viol_count,
  output logic [AW-1:0]                  viol_first_addr,
  output logic [$clog2(NUM_REQ)-1:0]     viol_first_src,
  output logic                           viol_seen
`endif
);
  localparam int SW = $clog2(NUM_REQ);

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, data_q;
  logic [AW-1:0] out_addr_q, out_data_q;
  logic [SW-1:0] src_q, out_src_q;
  entry_t        tbl_q [NUM_ENTRIES];
  logic          lock_q;

  logic [NUM_REQ-1:0] gnt_oh;
  logic [SW-1:0]      gnt_idx;
  logic               gnt_vld;
  logic               accept;
  logic               hit;

  assign accept = (state_q == S_IDLE) && gnt_vld && !rst;

  dma_rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .clk_i(clk),
    .rst_i(rst),
    .req_i(bus.req_valid),
    .adv_i(accept),
    .gnt_o(gnt_oh),
    .idx_o(gnt_idx),
    .vld_o(gnt_vld)
  );

  always_comb begin
    hit = 1'b0;
    for (int k = 0; k < NUM_ENTRIES; k++) begin
      if (entry_hit(tbl_q[k], addr_q)) hit = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (gnt_vld) state_d = S_CHECK;
      S_CHECK: state_d = S_SEND;
      S_SEND:  if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= '0;
      data_q     <= '0;
      src_q      <= '0;
      out_addr_q <= '0;
      out_data_q <= '0;
      out_src_q  <= '0;
    end else begin
      if (accept) begin
        addr_q <= bus.req_addr[gnt_idx*AW +: AW];
        data_q <= bus.req_data[gnt_idx*AW +: AW];
        src_q  <= gnt_idx;
      end
      if (state_q == S_CHECK) begin
        out_addr_q <= addr_q;
        out_data_q <= hit ? '0 : data_q;
        out_src_q  <= src_q;
      end
    end
  end

  // A write in the same cycle as the lock request still lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q <= 1'b0;
      for (int k = 0; k < NUM_ENTRIES; k++) begin
        if (k == 0) begin
          tbl_q[k].base <= RST_BASE0;
          tbl_q[k].mask <= '1;
          tbl_q[k].en   <= 1'b1;
        end else begin
          tbl_q[k] <= '0;
        end
      end
    end else begin
      lock_q <= lock_q | cfg_lock;
      if (cfg_we && !lock_q && (int'(cfg_idx) < NUM_ENTRIES)) begin
        tbl_q[cfg_idx].base <= cfg_base;
        tbl_q[cfg_idx].mask <= cfg_mask;
        tbl_q[cfg_idx].en   <= cfg_en;
      end
    end
  end

  assign bus.req_ready = accept ? gnt_oh : '0;
  assign bus.out_valid = (state_q == S_SEND);
  assign bus.out_addr  = out_addr_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
  assign locked        = lock_q;
  assign viol_pulse    = (state_q == S_CHECK) && hit;
  assign viol_src      = viol_pulse ? src_q : '0;

`ifdef DMA_FILTER_VIOL_LOG_EN
  logic [15:0]   cnt_q;
  logic [AW-1:0] first_addr_q;
  logic [SW-1:0] first_src_q;
  logic          seen_q;

  always_ff @(posedge clk) begin
    if (rst || log_clr) begin
      cnt_q        <= '0;
      first_addr_q <= '0;
      first_src_q  <= '0;
      seen_q       <= 1'b0;
    end else if (viol_pulse) begin
      if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
      if (!seen_q) begin
        seen_q       <= 1'b1;
        first_addr_q <= addr_q;
        first_src_q  <= src_q;
      end
    end
  end

  assign viol_count      = cnt_q;
  assign viol_first_addr = first_addr_q;
  assign viol_first_src  = first_src_q;
  assign viol_seen       = seen_q;
`endif

endmodule

// File: tb/tb_dma_filter_arbiter.sv
// Directed bench for dma_filter_arbiter: vector table plus
// hand-written stall, reset, config and lock sequences.
module tb_dma_filter_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [1:0]  cfg_idx;
  logic [31:0] cfg_base;
  logic [31:0] cfg_mask;
  logic        cfg_en;
  logic        cfg_lock;
  logic        locked;
  logic        viol_pulse;
  logic [1:0]  viol_src;
`ifdef DMA_FILTER_VIOL_LOG_EN
  logic        log_clr;
  logic [15:0] viol_count;
  logic [31:0] viol_first_addr;
  logic [1:0]  viol_first_src;
  logic        viol_seen;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  dma_filter_arbiter_if #(.NUM_REQ(4)) bus ();

  dma_filter_arbiter #(
    .NUM_REQ(4),
    .NUM_ENTRIES(4),
    .RST_BASE0(32'hF520_6000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .cfg_we(cfg_we),
    .cfg_idx(cfg_idx),
    .cfg_base(cfg_base),
    .cfg_mask(cfg_mask),
    .cfg_en(cfg_en),
    .cfg_lock(cfg_lock),
    .locked(locked),
    .viol_pulse(viol_pulse),
    .viol_src(viol_src)
`ifdef DMA_FILTER_VIOL_LOG_EN
    ,
    .log_clr(log_clr),
    .viol_count(viol_count),
    .viol_first_addr(viol_first_addr),
    .viol_first_src(viol_first_src),
    .viol_seen(viol_seen)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          src;
    logic [31:0] addr;
    logic [31:0] data;
    logic        blk;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic cfg_write(input logic [1:0] idx, input logic [31:0] b,
                           input logic [31:0] m, input logic e,
                           input logic lk);
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_idx  = idx;
    cfg_base = b;
    cfg_mask = m;
    cfg_en   = e;
    cfg_lock = lk;
    @(negedge clk);
    cfg_we   = 1'b0;
    cfg_lock = 1'b0;
  endtask

  // Single-requester transfer with out_ready high: T, T+1, T+2.
  task automatic do_xfer(input int s, input logic [31:0] a,
                         input logic [31:0] d, input logic blk);
    logic [3:0] oh;
    oh = 4'b0001 << s;
    @(negedge clk);
    bus.req_valid          = oh;
    bus.req_addr[s*32+:32] = a;
    bus.req_data[s*32+:32] = d;
    #1;
    chk("xfer_ready", 32'(bus.req_ready), 32'(oh));
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    chk("xfer_viol", 32'(viol_pulse), 32'(blk));
    chk("xfer_vsrc", 32'(viol_src), blk ? s : 0);
    chk("xfer_noready", 32'(bus.req_ready), 0);
    @(negedge clk);
    #1;
    chk("xfer_valid", 32'(bus.out_valid), 1);
    chk("xfer_addr", bus.out_addr, a);
    chk("xfer_data", bus.out_data, blk ? 32'h0 : d);
    chk("xfer_src", 32'(bus.out_src), s);
    chk("xfer_viol_once", 32'(viol_pulse), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{src: 0, addr: 32'hF520_6000, data: 32'hDEAD_BEEF, blk: 1'b1};
    vecs[1] = '{src: 1, addr: 32'hF520_6004, data: 32'h1234_5678, blk: 1'b0};
    vecs[2] = '{src: 2, addr: 32'hF520_6000, data: 32'h1111_1111, blk: 1'b1};
    vecs[3] = '{src: 3, addr: 32'h0000_1000, data: 32'hCAFE_F00D, blk: 1'b0};

    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.out_ready = 1'b1;
    cfg_we        = 1'b0;
    cfg_idx       = '0;
    cfg_base      = '0;
    cfg_mask      = '0;
    cfg_en        = 1'b0;
    cfg_lock      = 1'b0;
`ifdef DMA_FILTER_VIOL_LOG_EN
    log_clr       = 1'b0;
`endif

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_out_addr", bus.out_addr, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_src", 32'(bus.out_src), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_viol", 32'(viol_pulse), 0);
    chk("rst_vsrc", 32'(viol_src), 0);
    rst = 1'b0;

    for (int v = 0; v < 4; v++)
      do_xfer(vecs[v].src, vecs[v].addr, vecs[v].data, vecs[v].blk);

    // All requesters valid: pointer is back at 0 after src 3.
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      bus.req_addr[i*32+:32] = 32'h0000_1000 + 32'(i) * 32'h100;
      bus.req_data[i*32+:32] = 32'hA0 + 32'(i);
    end
    bus.req_valid = 4'hF;
    for (int g = 0; g < 5; g++) begin
      #1;
      chk("rr_grant", 32'(bus.req_ready), 32'(4'b0001 << (g % 4)));
      @(negedge clk);
      #1;
      chk("rr_check_noready", 32'(bus.req_ready), 0);
      @(negedge clk);
      #1;
      chk("rr_src", 32'(bus.out_src), g % 4);
      chk("rr_data", bus.out_data, 32'hA0 + 32'(g % 4));
      chk("rr_send_noready", 32'(bus.req_ready), 0);
      @(negedge clk);
    end
    bus.req_valid = '0;

    cfg_write(2'd1, 32'hF520_9000, 32'hFFFF_F000, 1'b1, 1'b0);
    do_xfer(2, 32'hF520_9028, 32'h55AA_55AA, 1'b1);
    do_xfer(1, 32'hF520_A000, 32'h0BAD_F00D, 1'b0);

    // Mask 0 blocks everything; overlap with entry 0 is one violation.
    cfg_write(2'd2, 32'h0, 32'h0, 1'b1, 1'b0);
    do_xfer(3, 32'h0000_0040, 32'h0000_0777, 1'b1);
    do_xfer(0, 32'hF520_6000, 32'h0000_0888, 1'b1);
    cfg_write(2'd2, 32'h0, 32'h0, 1'b0, 1'b0);
    do_xfer(3, 32'h0000_0040, 32'h0000_0999, 1'b0);

    @(negedge clk);
    cfg_lock = 1'b1;
    @(negedge clk);
    cfg_lock = 1'b0;
    #1;
    chk("lock_set", 32'(locked), 1);
    cfg_write(2'd1, 32'hF520_9000, 32'hFFFF_F000, 1'b0, 1'b0);
    #1;
    chk("lock_sticky", 32'(locked), 1);
    do_xfer(0, 32'hF520_9028, 32'h0000_ABCD, 1'b1);

    // Stall in SEND for 5 cycles, then release.
    @(negedge clk);
    bus.out_ready         = 1'b0;
    bus.req_valid         = 4'b0010;
    bus.req_addr[32+:32]  = 32'h0000_2000;
    bus.req_data[32+:32]  = 32'h0000_0077;
    #1;
    chk("stall_grant", 32'(bus.req_ready), 32'h2);
    @(negedge clk);
    bus.req_valid = 4'b1101;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("stall_valid", 32'(bus.out_valid), 1);
      chk("stall_addr", bus.out_addr, 32'h0000_2000);
      chk("stall_data", bus.out_data, 32'h0000_0077);
      chk("stall_src", 32'(bus.out_src), 1);
      chk("stall_noready", 32'(bus.req_ready), 0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    bus.req_valid = '0;
    @(negedge clk);
    #1;
    chk("stall_release", 32'(bus.out_valid), 0);

    // Second stall aborted by reset in its third SEND cycle.
    @(negedge clk);
    bus.out_ready         = 1'b0;
    bus.req_valid         = 4'b1000;
    bus.req_addr[96+:32]  = 32'h0000_3000;
    bus.req_data[96+:32]  = 32'h0000_0066;
    @(negedge clk);
    bus.req_valid = 4'hF;
    @(negedge clk);
    #1;
    chk("abort_send1", 32'(bus.out_valid), 1);
    @(negedge clk);
    #1;
    chk("abort_send2", 32'(bus.out_valid), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("abort_valid", 32'(bus.out_valid), 0);
    chk("abort_locked", 32'(locked), 0);
    chk("abort_noready", 32'(bus.req_ready), 0);
    rst           = 1'b0;
    bus.req_valid = '0;
    bus.out_ready = 1'b1;
    do_xfer(0, 32'hF520_9028, 32'h0000_1357, 1'b0);
    do_xfer(1, 32'hF520_6000, 32'h0000_2468, 1'b1);

    // Write together with lock is still accepted.
    cfg_write(2'd3, 32'h0000_3000, 32'hFFFF_FF00, 1'b1, 1'b1);
    #1;
    chk("wlock_locked", 32'(locked), 1);
    do_xfer(2, 32'h0000_3004, 32'h0000_4242, 1'b1);

`ifdef DMA_FILTER_VIOL_LOG_EN
    @(negedge clk);
    log_clr = 1'b1;
    @(negedge clk);
    log_clr = 1'b0;
    do_xfer(2, 32'hF520_6000, 32'h1, 1'b1);
    do_xfer(0, 32'hF520_6000, 32'h2, 1'b1);
    do_xfer(1, 32'hF520_6000, 32'h3, 1'b1);
    chk("log_count", 32'(viol_count), 3);
    chk("log_first_src", 32'(viol_first_src), 2);
    chk("log_first_addr", viol_first_addr, 32'hF520_6000);
    chk("log_seen", 32'(viol_seen), 1);
    @(negedge clk);
    log_clr = 1'b1;
    @(negedge clk);
    log_clr = 1'b0;
    #1;
    chk("log_clr_count", 32'(viol_count), 0);
    chk("log_clr_seen", 32'(viol_seen), 0);
    chk("log_clr_addr", viol_first_addr, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
